// File: rtl/uart_cmd_decoder_pkg.sv
// Opcode constants, decoder state encoding and small helpers
// shared by the UART command decoder and its bench.
package uart_cmd_pkg;

    localparam logic [7:0] CMD_WR_MEM_ACCESS_COUNT  = 8'hA0;
    localparam logic [7:0] CMD_RD_MEM_ACCESS_COUNT  = 8'hA1;
    localparam logic [7:0] CMD_WR_MEM_ACCESS_ADDR_0 = 8'hB0;
    localparam logic [7:0] CMD_WR_MEM_ACCESS_ADDR_1 = 8'hB1;
    localparam logic [7:0] CMD_WR_MEM_ACCESS_ADDR_2 = 8'hB2;
    localparam logic [7:0] CMD_WR_MEM_ACCESS_ADDR_3 = 8'hB3;
    localparam logic [7:0] CMD_RD_MEM_ACCESS_ADDR_0 = 8'hC0;
    localparam logic [7:0] CMD_RD_MEM_ACCESS_ADDR_1 = 8'hC1;
    localparam logic [7:0] CMD_RD_MEM_ACCESS_ADDR_2 = 8'hC2;
    localparam logic [7:0] CMD_RD_MEM_ACCESS_ADDR_3 = 8'hC3;
    localparam logic [7:0] CMD_DO_MEM_WRITE         = 8'hD0;
    localparam logic [7:0] CMD_DO_MEM_READ          = 8'hD1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_ARG,
        ST_RESPOND
    } state_t;

    function automatic logic [7:0] addr_byte(
        input logic [31:0] addr,
        input logic [1:0]  idx
    );
        return addr[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// Byte stream handshake between the UART RX/TX path and the decoder.
interface uart_cmd_decoder_if;

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;

    modport slave (
        input  rx_valid,
        input  rx_data,
        input  tx_ready,
        output tx_valid,
        output tx_data
    );

    modport master (
        output rx_valid,
        output rx_data,
        output tx_ready,
        input  tx_valid,
        input  tx_data
    );

endinterface

// File: rtl/uart_cmd_decoder.sv
// Register-access command decoder between UART RX and TX:
// owns the count/address registers and queues one reply byte.
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter bit          ACK_WRITES  = 1'b0,
    parameter logic [7:0]  COUNT_RESET = 8'h00,
    parameter logic [31:0] ADDR_RESET  = 32'h0
) (
    input  logic                clk,
    input  logic                reset,
    uart_cmd_decoder_if.slave   bus,
    output logic [7:0]          mem_access_count,
    output logic [31:0]         mem_access_addr,
    output logic                mem_wr_start,
    output logic                mem_rd_start,
    output logic                cmd_error,
    output logic                rx_overrun
);

    state_t      state_q, state_d;
    logic [7:0]  target_q, target_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q;
    logic [7:0]  count_q, count_d;
    logic [31:0] addr_q, addr_d;
    logic        wr_q, wr_d;
    logic        rd_q, rd_d;
    logic        err_q, err_d;
    logic        ovr_q, ovr_d;

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        tx_data_d = tx_data_q;
        count_d   = count_q;
        addr_d    = addr_q;
        wr_d      = 1'b0;
        rd_d      = 1'b0;
        err_d     = 1'b0;
        ovr_d     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.rx_valid) begin
                    case (bus.rx_data)
                        CMD_WR_MEM_ACCESS_COUNT,
                        CMD_WR_MEM_ACCESS_ADDR_0,
                        CMD_WR_MEM_ACCESS_ADDR_1,
                        CMD_WR_MEM_ACCESS_ADDR_2,
                        CMD_WR_MEM_ACCESS_ADDR_3: begin
                            target_d = bus.rx_data;
                            state_d  = ST_WAIT_ARG;
                        end
                        CMD_RD_MEM_ACCESS_COUNT: begin
                            tx_data_d = count_q;
                            state_d   = ST_RESPOND;
                        end
                        CMD_RD_MEM_ACCESS_ADDR_0,
                        CMD_RD_MEM_ACCESS_ADDR_1,
                        CMD_RD_MEM_ACCESS_ADDR_2,
                        CMD_RD_MEM_ACCESS_ADDR_3: begin
                            tx_data_d = addr_byte(addr_q, bus.rx_data[1:0]);
                            state_d   = ST_RESPOND;
                        end
                        CMD_DO_MEM_WRITE: wr_d  = 1'b1;
                        CMD_DO_MEM_READ:  rd_d  = 1'b1;
                        default:          err_d = 1'b1;
                    endcase
                end
            end
            ST_WAIT_ARG: begin
                // The argument is raw data, never an opcode.
                if (bus.rx_valid) begin
                    if (target_q == CMD_WR_MEM_ACCESS_COUNT) begin
                        count_d = bus.rx_data;
                    end else begin
                        addr_d[{target_q[1:0], 3'b000} +: 8] = bus.rx_data;
                    end
                    if (ACK_WRITES) begin
                        tx_data_d = target_q;
                        state_d   = ST_RESPOND;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RESPOND: begin
                if (bus.rx_valid) begin
                    ovr_d = 1'b1;
                end
                if (bus.tx_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            target_q   <= CMD_WR_MEM_ACCESS_COUNT;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            count_q    <= COUNT_RESET;
            addr_q     <= ADDR_RESET;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            err_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= (state_d == ST_RESPOND);
            count_q    <= count_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            err_q      <= err_d;
            ovr_q      <= ovr_d;
        end
    end

    assign bus.tx_valid      = tx_valid_q;
    assign bus.tx_data       = tx_data_q;
    assign mem_access_count  = count_q;
    assign mem_access_addr   = addr_q;
    assign mem_wr_start      = wr_q;
    assign mem_rd_start      = rd_q;
    assign cmd_error         = err_q;
    assign rx_overrun        = ovr_q;

endmodule

// File: doc/uart_cmd_decoder.md
# uart_cmd_decoder

Byte-level command decoder sitting between the UART receiver and the UART transmitter of the board-level peripheral. Consumes each received byte, executes the register-access protocol (memory-access count, 32-bit memory-access address, memory read/write triggers) and queues one response byte for read commands. Holds the architectural registers the host manipulates over the serial link.

## Interface
- ACK_WRITES, 0, when 1 a completed register write returns its opcode byte as acknowledgement
- COUNT_RESET, 8'h00, reset value of the access-count register
- ADDR_RESET, 32'h0, reset value of the access-address register
- clk  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-high reset
- rx_valid  in  1  one-cycle strobe: rx_data holds a new received byte
- rx_data  in  8  received byte
- tx_valid  out  1  response byte available
- tx_ready  in  1  transmitter accepts tx_data when tx_valid && tx_ready
- tx_data  out  8  response byte
- mem_access_count  out  8  count register
- mem_access_addr  out  32  address register
- mem_wr_start  out  1  one-cycle pulse on opcode D0
- mem_rd_start  out  1  one-cycle pulse on opcode D1
- cmd_error  out  1  one-cycle pulse on unrecognised opcode
- rx_overrun  out  1  one-cycle pulse when a byte is dropped in RESPOND

## Operation
- Opcodes: A0 write count, A1 read count, B0..B3 write address byte 0..3, C0..C3 read address byte 0..3, D0 memory write, D1 memory read. Byte n covers addr[8n+7:8n].
- States: IDLE, WAIT_ARG, RESPOND.
- IDLE, rx_valid: A0/B0..B3 -> latch target, WAIT_ARG. A1/C0..C3 -> load tx_data with selected byte, RESPOND. D0/D1 -> pulse start, stay IDLE. Other -> pulse cmd_error, stay IDLE.
- WAIT_ARG, rx_valid: write byte into target; ACK_WRITES=1 -> tx_data=opcode, RESPOND; else IDLE. Argument byte never decoded as opcode, even if it matches one.
- RESPOND: tx_valid=1, tx_data stable until handshake; on handshake -> IDLE. rx_valid here -> byte dropped, rx_overrun pulse, no state change.
- Read response reflects register value at the cycle the read opcode is accepted.
- Reset values: state IDLE, tx_valid 0, tx_data 8'h00, all pulses 0, count COUNT_RESET, addr ADDR_RESET.

## Timing
- All outputs registered. rx_valid at edge N -> register update, tx_valid, start/error pulses visible after edge N+1 (latency 1).
- Pulses high exactly one cycle.
- Handshake at edge M -> tx_valid low after M; next response no earlier than M+2.
- Reset dominates any same-cycle rx_valid or handshake; reset in WAIT_ARG discards pending target, next byte is an opcode.
- No combinational path rx_* -> tx_*; tx_ready influences only state.

## Structure
- Package uart_cmd_pkg: opcode constants (CMD_WR_MEM_ACCESS_COUNT, CMD_RD_MEM_ACCESS_COUNT, CMD_WR/RD_MEM_ACCESS_ADDR_0..3, CMD_DO_MEM_WRITE/READ) and state enum, shared with testbench.
- Single module; no sub-module warranted.

## Test plan
- Reset, send A1 -> tx_data 8'h00, tx_valid until tx_ready; count 8'h00, addr 32'h0.
- A0,34 then A1 -> count 8'h34 one cycle after argument; response 8'h34.
- B0 AB, B1 CD, B2 EF, B3 CD -> addr 32'hCDEFCDAB; C2 -> 8'hEF; C0 -> 8'hAB.
- A1 with tx_ready low 5 cycles -> tx_data stable 8'h34; byte 8'hC0 meanwhile -> rx_overrun pulse, no second response.
- 8'h55 -> cmd_error one cycle, no tx; D0 -> mem_wr_start one cycle; D1 -> mem_rd_start one cycle.
- A0 then reset then A1 -> count unchanged, A1 decoded as opcode, response 8'h00; ACK_WRITES=1: A0,12 -> response 8'hA0.
